// File: rtl/nf10_axi_lite_master_if.sv
// AXI4-Lite bus bundle between the register master and a pcore s_axi_* port.
// The master modport drives address/data/valid and the response readies.
// The slave modport is the mirror image, for pcores or models on the far side.
interface nf10_axi_lite_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // Write address channel
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;

  // Write data channel
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;

  // Write response channel
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  // Read address channel
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;

  // Read data channel
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

endinterface

// File: rtl/nf10_axi_lite_master.sv
// nf10_axi_lite_master: single-outstanding AXI4-Lite initiator.
// It accepts one register command at a time and runs it as an AXI4-Lite
// write or read. It then presents a single response. A per-transaction
// timeout aborts the transaction with SLVERR if the slave stops responding.
module nf10_axi_lite_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,   // only 32 is supported
  parameter int C_TIMEOUT_CYCLES   = 64    // legal range 2..65535
) (
  input  logic                            m_axi_aclk,
  input  logic                            m_axi_aresetn,

  // Command side
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_rnw,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,

  // Response side
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,

  // AXI4-Lite master port
  nf10_axi_lite_master_if.master          m_axi
);

  // FSM encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR      = 3'd1;
  localparam logic [2:0] ST_WR_RESP = 3'd2;
  localparam logic [2:0] ST_RD      = 3'd3;
  localparam logic [2:0] ST_RD_DATA = 3'd4;
  localparam logic [2:0] ST_RESP    = 3'd5;

  localparam int         STRB_W      = C_M_AXI_DATA_WIDTH / 8;
  // Last count value that may be spent waiting before the transaction aborts
  localparam logic [15:0] TMO_LAST   = 16'(C_TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  // Reset synchroniser: assertion is asynchronous, release follows the clock
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  // Control and datapath state
  logic [2:0]                      state_q,       state_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q,        addr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q,       wdata_d;
  logic [STRB_W-1:0]               wstrb_q,       wstrb_d;
  logic                            awvalid_q,     awvalid_d;
  logic                            wvalid_q,      wvalid_d;
  logic                            arvalid_q,     arvalid_d;
  logic                            bready_q,      bready_d;
  logic                            rready_q,      rready_d;
  logic                            rsp_valid_q,   rsp_valid_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata_q,   rsp_rdata_d;
  logic [1:0]                      rsp_resp_q,    rsp_resp_d;
  logic                            rsp_timeout_q, rsp_timeout_d;
  logic [15:0]                     tmo_cnt_q,     tmo_cnt_d;

  // Combinational helpers
  logic        aw_left;
  logic        w_left;
  logic        tmo_expired;
  logic        do_abort;
  logic [15:0] tmo_cnt_inc;

  assign rst_int_n   = rst_sync_q[1];
  // The counter saturates so it can never wrap back below the limit
  assign tmo_cnt_inc = (tmo_cnt_q == 16'hFFFF) ? tmo_cnt_q : (tmo_cnt_q + 16'd1);
  assign tmo_expired = (tmo_cnt_q >= TMO_LAST);

  // Output wiring: all outputs come straight from registers
  assign cmd_ready     = (state_q == ST_IDLE) && rst_int_n;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_timeout   = rsp_timeout_q;

  assign m_axi.awaddr  = addr_q;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

  // Reset synchroniser: assert immediately, release two clock edges later
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  // Next-state logic: command capture, channel tracking, timeout abort
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    arvalid_d     = arvalid_q;
    bready_d      = bready_q;
    rready_d      = rready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    tmo_cnt_d     = tmo_cnt_q;
    aw_left       = 1'b0;
    w_left        = 1'b0;
    do_abort      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          tmo_cnt_d = 16'd0;
          if (cmd_rnw) begin
            arvalid_d = 1'b1;
            state_d   = ST_RD;
          end else begin
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WR: begin
        // Each valid stays up only until its own handshake
        aw_left   = awvalid_q & ~m_axi.awready;
        w_left    = wvalid_q  & ~m_axi.wready;
        awvalid_d = aw_left;
        wvalid_d  = w_left;
        tmo_cnt_d = tmo_cnt_inc;
        if (!aw_left && !w_left) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end else if (tmo_expired) begin
          do_abort = 1'b1;
        end else begin
          state_d = ST_WR;
        end
      end

      ST_WR_RESP: begin
        tmo_cnt_d = tmo_cnt_inc;
        if (m_axi.bvalid && bready_q) begin
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = {C_M_AXI_DATA_WIDTH{1'b0}};
          rsp_resp_d    = m_axi.bresp;
          rsp_timeout_d = 1'b0;
          state_d       = ST_RESP;
        end else if (tmo_expired) begin
          do_abort = 1'b1;
        end else begin
          state_d = ST_WR_RESP;
        end
      end

      ST_RD: begin
        tmo_cnt_d = tmo_cnt_inc;
        if (arvalid_q && m_axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_DATA;
        end else if (tmo_expired) begin
          do_abort = 1'b1;
        end else begin
          state_d = ST_RD;
        end
      end

      ST_RD_DATA: begin
        tmo_cnt_d = tmo_cnt_inc;
        if (m_axi.rvalid && rready_q) begin
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = m_axi.rdata;
          rsp_resp_d    = m_axi.rresp;
          rsp_timeout_d = 1'b0;
          state_d       = ST_RESP;
        end else if (tmo_expired) begin
          do_abort = 1'b1;
        end else begin
          state_d = ST_RD_DATA;
        end
      end

      ST_RESP: begin
        // Response fields are held until the requester takes them
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end

      default: begin
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        arvalid_d   = 1'b0;
        bready_d    = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase

    // Abort: release the bus and report SLVERR with the timeout flag.
    // bready/rready go low, so a late bvalid/rvalid is never taken.
    if (do_abort) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      arvalid_d     = 1'b0;
      bready_d      = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_rdata_d   = {C_M_AXI_DATA_WIDTH{1'b0}};
      rsp_resp_d    = RESP_SLVERR;
      rsp_timeout_d = 1'b1;
      state_d       = ST_RESP;
    end else begin
      tmo_cnt_d = tmo_cnt_d;
    end
  end

  // State and output registers; reset drops every output at once
  always_ff @(posedge m_axi_aclk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q       <= ST_IDLE;
      addr_q        <= {C_M_AXI_ADDR_WIDTH{1'b0}};
      wdata_q       <= {C_M_AXI_DATA_WIDTH{1'b0}};
      wstrb_q       <= {STRB_W{1'b0}};
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      bready_q      <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= {C_M_AXI_DATA_WIDTH{1'b0}};
      rsp_resp_q    <= 2'b00;
      rsp_timeout_q <= 1'b0;
      tmo_cnt_q     <= 16'd0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      arvalid_q     <= arvalid_d;
      bready_q      <= bready_d;
      rready_q      <= rready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
      tmo_cnt_q     <= tmo_cnt_d;
    end
  end

endmodule

// File: tb/tb_nf10_axi_lite_master.sv
// Directed bench for nf10_axi_lite_master. A configurable slave model
// drives the AXI inputs on the falling edge. Expected responses are queued
// when each command is issued and compared when the response is taken.
module tb_nf10_axi_lite_master;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rnw;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;

  nf10_axi_lite_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  nf10_axi_lite_master #(
    .C_M_AXI_ADDR_WIDTH (32),
    .C_M_AXI_DATA_WIDTH (32),
    .C_TIMEOUT_CYCLES   (64)
  ) dut (
    .m_axi_aclk    (clk),
    .m_axi_aresetn (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_rnw       (cmd_rnw),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .cmd_wstrb     (cmd_wstrb),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_resp      (rsp_resp),
    .rsp_timeout   (rsp_timeout),
    .m_axi         (bus)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        tmo;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Slave model configuration (written by the main sequence only)
  int          aw_lat    = 0;
  int          w_lat     = 0;
  int          ar_lat    = 0;
  int          r_lat     = 0;
  logic        ar_never  = 1'b0;
  logic [1:0]  bresp_cfg = 2'b00;
  logic [1:0]  rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = 32'h0000_0000;

  // Handshake counters (written by the slave model only)
  int aw_hs_cnt = 0;
  int w_hs_cnt  = 0;
  int ar_hs_cnt = 0;

  // Clock generation
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the bench can never hang
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Slave model: reacts to handshakes of the previous rising edge, then drives
  // readies and responses for the next one
  initial begin : slave_model
    int   aw_wait, w_wait, ar_wait, r_wait;
    logic aw_done, w_done, r_pend;
    logic aw_v_s, w_v_s, ar_v_s, b_r_s, r_r_s;
    aw_wait = 0; w_wait = 0; ar_wait = 0; r_wait = 0;
    aw_done = 1'b0; w_done = 1'b0; r_pend = 1'b0;
    aw_v_s = 1'b0; w_v_s = 1'b0; ar_v_s = 1'b0; b_r_s = 1'b0; r_r_s = 1'b0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
    bus.bvalid = 1'b0; bus.bresp = 2'b00;
    bus.rvalid = 1'b0; bus.rresp = 2'b00; bus.rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        aw_wait = 0; w_wait = 0; ar_wait = 0; r_wait = 0;
        aw_done = 1'b0; w_done = 1'b0; r_pend = 1'b0;
        bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
        bus.bvalid = 1'b0; bus.rvalid = 1'b0;
      end else begin
        if (bus.awready && aw_v_s) begin aw_hs_cnt++; aw_done = 1'b1; aw_wait = 0; end
        if (bus.wready && w_v_s) begin w_hs_cnt++; w_done = 1'b1; w_wait = 0; end
        if (bus.arready && ar_v_s) begin ar_hs_cnt++; r_pend = 1'b1; r_wait = 0; ar_wait = 0; end
        if (bus.bvalid && b_r_s) bus.bvalid = 1'b0;
        if (bus.rvalid && r_r_s) bus.rvalid = 1'b0;
        if (aw_done && w_done && !bus.bvalid) begin
          bus.bvalid = 1'b1; bus.bresp = bresp_cfg; aw_done = 1'b0; w_done = 1'b0;
        end
        if (r_pend && !bus.rvalid) begin
          if (r_wait >= r_lat) begin
            bus.rvalid = 1'b1; bus.rdata = rdata_cfg; bus.rresp = rresp_cfg; r_pend = 1'b0;
          end else begin
            r_wait++;
          end
        end
        bus.awready = bus.awvalid && (aw_wait >= aw_lat);
        if (bus.awvalid && !bus.awready) aw_wait++;
        bus.wready = bus.wvalid && (w_wait >= w_lat);
        if (bus.wvalid && !bus.wready) w_wait++;
        bus.arready = bus.arvalid && !ar_never && (ar_wait >= ar_lat);
        if (bus.arvalid && !bus.arready) ar_wait++;
      end
      aw_v_s = bus.awvalid; w_v_s = bus.wvalid; ar_v_s = bus.arvalid;
      b_r_s = bus.bready; r_r_s = bus.rready;
    end
  end

  // Issue one command from a falling edge; returns on the falling edge after acceptance
  task automatic issue(input logic rnw, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [31:0] erd,
                       input logic [1:0] eresp, input logic etmo);
    int n;
    exp_t e;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk("cmd_ready_before_issue", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_rnw = rnw; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
    e.rdata = erd; e.resp = eresp; e.tmo = etmo;
    sb_q.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Take one response with rsp_ready high and compare it with the scoreboard
  task automatic collect(input int budget);
    int   n;
    exp_t e;
    n = 0;
    rsp_ready = 1'b1;
    while (!rsp_valid && n < budget) begin @(negedge clk); n++; end
    chk("rsp_valid_within_budget", {31'd0, rsp_valid}, 32'd1);
    chk("scoreboard_nonempty", {31'd0, (sb_q.size() != 0)}, 32'd1);
    if (rsp_valid && sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("rsp_rdata", rsp_rdata, e.rdata);
      chk("rsp_resp", {30'd0, rsp_resp}, {30'd0, e.resp});
      chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e.tmo});
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drops", {31'd0, rsp_valid}, 32'd0);
    chk("cmd_ready_reasserts", {31'd0, cmd_ready}, 32'd1);
  endtask

  // Main directed sequence
  initial begin : main_seq
    int   n;
    int   base_aw, base_w;
    logic bad;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_addr = 32'h0;
    cmd_wdata = 32'h0; cmd_wstrb = 4'h0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_valids", {29'd0, bus.awvalid, bus.wvalid, bus.arvalid}, 32'd0);
    chk("rst_readies", {30'd0, bus.bready, bus.rready}, 32'd0);
    chk("rst_awaddr", bus.awaddr, 32'h0);
    chk("rst_rsp_fields", {29'd0, rsp_resp, rsp_timeout}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("cmd_ready_after_release", {31'd0, cmd_ready}, 32'd1);

    // 1: zero-wait write, cycle-exact latency
    issue(1'b0, 32'h7920_0004, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b00, 1'b0);
    chk("t1_aw_w_valid", {30'd0, bus.awvalid, bus.wvalid}, 32'd3);
    chk("t1_awaddr", bus.awaddr, 32'h7920_0004);
    chk("t1_wdata", bus.wdata, 32'hDEAD_BEEF);
    chk("t1_wstrb", {28'd0, bus.wstrb}, 32'hF);
    chk("t1_cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    chk("t1_valids_dropped", {30'd0, bus.awvalid, bus.wvalid}, 32'd0);
    chk("t1_bready", {31'd0, bus.bready}, 32'd1);
    chk("t1_rsp_not_yet", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("t1_rsp_at_edge3", {31'd0, rsp_valid}, 32'd1);
    collect(5);

    // 2: read with arready held low for 5 cycles
    ar_lat = 5; rdata_cfg = 32'h1234_5678; rresp_cfg = 2'b00;
    issue(1'b1, 32'h7920_0008, 32'h0, 4'h0, 32'h1234_5678, 2'b00, 1'b0);
    n = 0; bad = 1'b0;
    while (bus.arvalid && n < 100) begin
      if (bus.araddr !== 32'h7920_0008) bad = 1'b1;
      n++;
      @(negedge clk);
    end
    chk("t2_arvalid_cycles", n, 32'd6);
    chk("t2_araddr_stable", {31'd0, bad}, 32'd0);
    collect(20);
    chk("t2_rdata_hold", rsp_rdata, 32'h1234_5678);
    ar_lat = 0;

    // 3: write where W completes 3 cycles before AW
    aw_lat = 3; base_aw = aw_hs_cnt; base_w = w_hs_cnt;
    issue(1'b0, 32'h7920_0010, 32'hA5A5_5A5A, 4'b0011, 32'h0, 2'b00, 1'b0);
    @(negedge clk);
    chk("t3_w_dropped_aw_held", {30'd0, bus.awvalid, bus.wvalid}, 32'd2);
    collect(20);
    chk("t3_aw_handshakes", aw_hs_cnt - base_aw, 32'd1);
    chk("t3_w_handshakes", w_hs_cnt - base_w, 32'd1);
    aw_lat = 0;

    // 4: read to a slave that never takes the address
    ar_never = 1'b1;
    issue(1'b1, 32'h7920_000C, 32'h0, 4'h0, 32'h0, 2'b10, 1'b1);
    n = 0;
    while (bus.arvalid && n < 200) begin n++; @(negedge clk); end
    chk("t4_arvalid_cycles", n, 32'd64);
    collect(10);
    ar_never = 1'b0; rdata_cfg = 32'hCAFE_F00D;
    issue(1'b1, 32'h7920_0000, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b00, 1'b0);
    collect(20);

    // 4b: address handshake on the very cycle the count expires
    ar_lat = 63; rdata_cfg = 32'h0BAD_F00D;
    issue(1'b1, 32'h7920_0014, 32'h0, 4'h0, 32'h0BAD_F00D, 2'b00, 1'b0);
    n = 0;
    while (bus.arvalid && n < 200) begin n++; @(negedge clk); end
    chk("t4b_arvalid_cycles", n, 32'd64);
    collect(10);
    ar_lat = 0;

    // 5: DECERR write response held while rsp_ready stays low
    bresp_cfg = 2'b11;
    issue(1'b0, 32'h7920_0018, 32'h0000_00FF, 4'h1, 32'h0, 2'b11, 1'b0);
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    chk("t5_rsp_seen", {31'd0, rsp_valid}, 32'd1);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!rsp_valid || rsp_resp !== 2'b11 || cmd_ready !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    chk("t5_held_stable", {31'd0, bad}, 32'd0);
    collect(5);
    bresp_cfg = 2'b00;

    // 6: reset in the middle of RD_DATA
    r_lat = 20; rdata_cfg = 32'h5555_AAAA;
    issue(1'b1, 32'h7920_001C, 32'h0, 4'h0, 32'h5555_AAAA, 2'b00, 1'b0);
    n = 0;
    while (!bus.rready && n < 50) begin @(negedge clk); n++; end
    chk("t6_in_rd_data", {31'd0, bus.rready}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valids", {29'd0, bus.awvalid, bus.wvalid, bus.arvalid}, 32'd0);
    chk("t6_rst_readies", {30'd0, bus.bready, bus.rready}, 32'd0);
    chk("t6_rst_cmd_rsp", {30'd0, cmd_ready, rsp_valid}, 32'd0);
    chk("t6_rst_araddr", bus.araddr, 32'h0);
    chk("t6_rst_rsp_rdata", rsp_rdata, 32'h0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    r_lat = 0;
    rst_n = 1'b1;
    issue(1'b0, 32'h7920_0020, 32'h1122_3344, 4'hF, 32'h0, 2'b00, 1'b0);
    collect(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nf10_axi_lite_master.md
Name: nf10_axi_lite_master

Overview:
- Single-outstanding AXI4-Lite initiator: turns one-at-a-time register commands into AXI4-Lite write or read transactions.
- Drives the s_axi_* register port of NetFPGA-10G pcores (host-bridge side and simulation register driver).
- Bounded timeout, so an unresponsive slave cannot hang the requester.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, address width.
- C_M_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_TIMEOUT_CYCLES, 64, cycles allowed per transaction before abort; legal range 2..65535.

Ports:
- m_axi_aclk  in  1  clock.
- m_axi_aresetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_rnw  in  1  1=read, 0=write.
- cmd_addr  in  32  target address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write byte strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  AXI response code.
- rsp_timeout  out  1  transaction aborted by timeout.
- m_axi_awaddr  out  32; m_axi_awvalid out 1; m_axi_awready in 1.
- m_axi_wdata  out  32; m_axi_wstrb out 4; m_axi_wvalid out 1; m_axi_wready in 1.
- m_axi_bresp  in  2; m_axi_bvalid in 1; m_axi_bready out 1.
- m_axi_araddr  out  32; m_axi_arvalid out 1; m_axi_arready in 1.
- m_axi_rdata  in  32; m_axi_rresp in 2; m_axi_rvalid in 1; m_axi_rready out 1.

Behaviour:
- Reset (async assert, sync deassert internally):
  - State = IDLE.
  - All *valid, bready, rready, rsp_valid, rsp_timeout = 0.
  - Address, data, rsp_rdata, rsp_resp = 0.
  - cmd_ready = 1 after reset is released.
- Reset mid-transaction: all outputs return immediately to reset values and the command is lost; the requester reissues.
- cmd_ready = 1 only in IDLE (decoded from state register). A command is captured on the accepting edge.
- FSM states: IDLE, WR, WR_RESP, RD, RD_DATA, RESP.
- IDLE -> WR (cmd_rnw=0):
  - Registers awaddr, wdata, wstrb.
  - Asserts awvalid and wvalid together on the next cycle.
- WR:
  - awvalid drops the cycle after its own handshake; wvalid likewise.
  - AW and W are tracked independently, so either may complete first or both in the same cycle.
  - Address and data stay stable while valid is high.
  - Moves to WR_RESP once both have handshaken.
- WR_RESP:
  - bready = 1.
  - On bvalid: capture bresp into rsp_resp, set rsp_rdata = 0, go to RESP.
- IDLE -> RD (cmd_rnw=1):
  - arvalid asserted with araddr stable until arready; then go to RD_DATA.
- RD_DATA:
  - rready = 1.
  - On rvalid: capture rdata and rresp, go to RESP.
- RESP:
  - rsp_valid = 1, outputs held stable until rsp_ready.
  - On rsp_ready: rsp_valid drops next cycle; return to IDLE.
  - cmd_ready reasserts that cycle, so back-to-back commands are spaced by at least one idle cycle.
- Latency against a zero-wait slave (all ready inputs = 1, bvalid/rvalid returned the cycle after handshake):
  - Accept at edge 0, AXI valid at edge 1, response handshake at edge 2, rsp_valid at edge 3.
  - Command-to-response is 3 cycles.
- Timeout:
  - 16-bit counter cleared on command accept; increments every cycle in WR, WR_RESP, RD and RD_DATA.
  - When the count reaches C_TIMEOUT_CYCLES-1 without completion: drop all valid and ready outputs next cycle and go to RESP.
  - Response on abort: rsp_resp = 2'b10, rsp_timeout = 1, rsp_rdata = 0.
  - If a handshake completes on the same cycle the count expires, completion wins and no timeout is flagged.
  - Late bvalid/rvalid after an abort is ignored (bready/rready stay 0 outside their states).
- SLVERR/DECERR from the slave is passed through unchanged with rsp_timeout = 0.
- Response hold: rsp_rdata, rsp_resp and rsp_timeout hold their last value until the next response loads.

Test Plan:
- Write 0x79200004 <- 0xDEADBEEF, wstrb 0xF, zero-wait slave -> awaddr/wdata seen on edge 1; rsp_valid on edge 3 with rsp_resp=0, rsp_timeout=0, rsp_rdata=0.
- Read 0x79200008; slave holds arready low 5 cycles, then returns 0x12345678 with rresp OKAY -> araddr stable throughout; rsp_rdata=0x12345678, rsp_resp=0.
- Write where wready arrives 3 cycles before awready -> wvalid drops after the W handshake, awvalid persists; exactly one handshake per channel; response OKAY.
- Read to a slave that never asserts arready, C_TIMEOUT_CYCLES=64 -> arvalid drops after 64 cycles; rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0; a following read completes normally.
- Write returning bresp=2'b11; rsp_ready held low 10 cycles -> rsp_valid and rsp_resp=2'b11 held stable; cmd_ready=0 until the response handshake.
- Assert reset during RD_DATA -> all outputs return to reset values immediately; after release, cmd_ready=1 and a new write completes.
